prog_uart_loader: RTL
=====================

Name: prog_uart_loader

Overview:
- Programming-path front end of the SoC: receives the host byte stream on the programming UART pin and packs bytes into 32-bit little-endian words.
- Writes each word sequentially into instruction memory through a req/gnt port.
- Raises boot_o when the end-of-program word arrives, releasing the core from reset.
- Sits between the pad-level rx/prog pins and the instruction memory inside the programming-UART top.

Parameters:
ADDR_W, 32, width of mem_addr_o
BASE_ADDR, 32'h0000_0000, byte address of the first word written
END_WORD, 32'h0000_0FFF, terminator word; ends programming, is not written
SYNC_STAGES, 2, flop stages on io_rx_i and prog_i

Ports:
clock  in  1  single system clock
reset  in  1  asynchronous, active-high reset
io_rx_i  in  1  UART serial input, 8N1, idle high
io_CLK_PER_BIT  in  16  clocks per bit, sampled at each start-bit detect
prog_i  in  1  programming enable (asynchronous pin)
mem_req_o  out  1  write request, held until granted
mem_addr_o  out  ADDR_W  byte address, word aligned
mem_wdata_o  out  32  write data
mem_gnt_i  in  1  grant; the write completes on the cycle where req & gnt
boot_o  out  1  core-release / boot flag
frame_err_o  out  1  one-cycle pulse on a bad stop bit
overrun_o  out  1  sticky; a byte was lost

Behaviour:
- Reset (async, active-high) clears every flop:
  - mem_req_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0.
  - boot_o=0, frame_err_o=0, overrun_o=0.
  - RX FSM goes to IDLE; loader FSM goes to WAIT.
- Synchronisers:
  - io_rx_i and prog_i pass through SYNC_STAGES flops.
  - The rx synchroniser resets to 1, the prog synchroniser to 0.
  - Every use below refers to the synchronised signals.
- RX FSM states IDLE, START, DATA, STOP, with a 16-bit counter cnt and a 3-bit bit index:
  - Bit period P is latched from io_CLK_PER_BIT on the falling edge of rx in IDLE. Values below 4 are clamped to 4.
  - START: at cnt=P/2-1, if rx=1 (glitch) go to IDLE; otherwise go to DATA with cnt cleared.
  - DATA: sample rx at cnt=P-1, shifting LSB first. After 8 bits go to STOP.
  - STOP: sample at cnt=P-1.
    - rx=1: byte_valid pulses for one cycle.
    - rx=0: frame_err_o pulses for one cycle and the byte is discarded.
    - Either way, go to IDLE.
- Byte holding register (1 deep):
  - byte_valid loads it.
  - If it is still full when a new byte_valid arrives, the new byte is dropped and overrun_o is set (cleared only by reset).
- Loader FSM states WAIT, COLLECT, WRITE, DONE:
  - WAIT: prog=0. Bytes are discarded, the lane counter is 0 and the address is BASE_ADDR. prog=1 moves to COLLECT.
  - COLLECT: pops the holding register. Byte n goes to word[8n+7:8n], n=0..3.
  - On the 4th byte:
    - If the word equals END_WORD: go to DONE with no write.
    - Otherwise: go to WRITE with mem_req_o=1 on the next cycle.
  - WRITE: mem_addr_o, mem_wdata_o and mem_req_o stay stable until mem_gnt_i.
    - On grant: mem_req_o=0 on the next cycle, address += 4 (wraps modulo 2^ADDR_W), return to COLLECT.
    - The holding register keeps filling during WRITE.
  - DONE: boot_o=1 (registered, asserted the cycle after the terminator byte). Incoming bytes are ignored.
- prog deassert:
  - In COLLECT: go to WAIT. The partial word is discarded.
  - In WRITE: the pending request is held until granted, then go to WAIT. A request is never withdrawn.
  - In DONE: stay in DONE; boot_o stays 1.
- prog rising edge while in DONE: boot_o=0 and the FSM goes to COLLECT with address BASE_ADDR (reprogram).
- Simultaneous events:
  - byte_valid in the same cycle as a holding-register pop: the new byte is accepted and no overrun is flagged.
  - Grant and prog fall in the same cycle: the write completes, then the FSM goes to WAIT.
- Reset mid-frame or mid-request returns immediately to the reset values, including dropping mem_req_o.

Test Plan:
- Single word: P=16, prog=1, send 0x13,0x05,0x00,0x00 with gnt tied 1 -> exactly one req with addr 0x0, wdata 0x0000_0513; addr becomes 0x4.
- Multi-word with terminator: send words 0x00A00093, 0x00108113, then 0x00000FFF -> writes at 0x0 and 0x4 only; boot_o=1 the cycle after the last stop sample; no third req.
- Stalled grant: hold gnt=0 for 200 cycles during a write while one byte arrives -> req/addr/wdata stable throughout, overrun_o=0; a second byte arriving while the holding register is still full -> overrun_o=1 and that byte is lost.
- Framing: send 0x55 with stop bit 0 -> frame_err_o is high for exactly 1 cycle and the lane counter is unchanged. A 3-cycle low glitch on rx with P=16 -> no byte and no error.
- Abort: deassert prog after 2 bytes -> FSM goes to WAIT. Reassert and send 4 bytes -> write at BASE_ADDR containing only the new bytes.
- Async reset asserted mid-WRITE (req=1) -> mem_req_o=0 and boot_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prog_uart_loader.sv
// Programming-UART loader: receives 8N1 bytes from the host, packs them into
// little-endian 32-bit words and writes them sequentially into instruction
// memory over a req/gnt port. A terminator word releases the core (boot_o).
module prog_uart_loader #(
   parameter int unsigned ADDR_W      = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_rx_i,
   input  logic [15:0]       io_CLK_PER_BIT,
   input  logic              prog_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   output logic              boot_o,
   output logic              frame_err_o,
   output logic              overrun_o
);

   localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LD_WAIT, LD_COLLECT, LD_WRITE, LD_DONE} ld_state_t;

   // Bit periods shorter than 4 clocks leave no room for a mid-bit sample.
   function automatic logic [15:0] clamp_period(input logic [15:0] p);
      return (p < 16'd4) ? 16'd4 : p;
   endfunction

   logic [SYNC_STAGES-1:0] rx_sync;
   logic [SYNC_STAGES-1:0] prog_sync;
   logic                   rx_s;
   logic                   prog_s;
   logic                   rx_d;
   logic                   prog_d;

   rx_state_t   rx_state, rx_next;
   logic [15:0] period;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        half_hit;
   logic        full_hit;
   logic        start_edge;
   logic        byte_valid;
   logic        stop_bad;

   logic        hold_full;
   logic [7:0]  hold_data;
   logic        avail;
   logic [7:0]  cur_byte;
   logic        pop;
   logic        take;

   ld_state_t   ld_state, ld_next;
   logic [1:0]  lane;
   logic [23:0] word_q;
   logic [31:0] full_word;
   logic        prog_rise;

   assign rx_s   = rx_sync[SYNC_STAGES-1];
   assign prog_s = prog_sync[SYNC_STAGES-1];

   // Pin synchronisers plus one extra flop each for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_sync   <= '1;
         prog_sync <= '0;
         rx_d      <= 1'b1;
         prog_d    <= 1'b0;
      end else begin
         rx_sync[0]   <= io_rx_i;
         prog_sync[0] <= prog_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rx_sync[i]   <= rx_sync[i-1];
            prog_sync[i] <= prog_sync[i-1];
         end
         rx_d   <= rx_s;
         prog_d <= prog_s;
      end
   end

   assign start_edge = rx_d & ~rx_s;
   assign half_hit   = (cnt == ({1'b0, period[15:1]} - 16'd1));
   assign full_hit   = (cnt == (period - 16'd1));
   assign prog_rise  = prog_s & ~prog_d;

   // RX FSM next-state and the stop-bit strobes.
   always_comb begin
      rx_next    = rx_state;
      byte_valid = 1'b0;
      stop_bad   = 1'b0;
      case (rx_state)
         RX_IDLE:  if (start_edge) rx_next = RX_START;
         RX_START: if (half_hit) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_hit && (bit_idx == 3'd7)) rx_next = RX_STOP;
         RX_STOP: begin
            if (full_hit) begin
               rx_next    = RX_IDLE;
               byte_valid = rx_s;
               stop_bad   = ~rx_s;
            end
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   // RX FSM state, bit timing counter and LSB-first shift register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state    <= RX_IDLE;
         period      <= '0;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         frame_err_o <= 1'b0;
      end else begin
         rx_state    <= rx_next;
         frame_err_o <= stop_bad;
         case (rx_state)
            RX_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (start_edge) period <= clamp_period(io_CLK_PER_BIT);
            end
            RX_START: cnt <= half_hit ? 16'd0 : cnt + 16'd1;
            RX_DATA: begin
               if (full_hit) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RX_STOP: cnt <= cnt + 16'd1;
            default: cnt <= '0;
         endcase
      end
   end

   // A fresh byte bypasses the holding register when it is empty, so a byte
   // can be consumed in the same cycle its stop bit is sampled.
   assign avail     = hold_full | byte_valid;
   assign cur_byte  = hold_full ? hold_data : shreg;
   assign full_word = {cur_byte, word_q};

   // Loader FSM next-state, byte pop and word-capture decisions.
   always_comb begin
      ld_next = ld_state;
      pop     = 1'b0;
      take    = 1'b0;
      case (ld_state)
         LD_WAIT: begin
            pop = avail;
            if (prog_s) ld_next = LD_COLLECT;
         end
         LD_COLLECT: begin
            if (!prog_s) begin
               ld_next = LD_WAIT;
            end else if (avail) begin
               pop  = 1'b1;
               take = 1'b1;
               if (lane == 2'd3)
                  ld_next = (full_word == END_WORD) ? LD_DONE : LD_WRITE;
            end
         end
         LD_WRITE: begin
            if (mem_gnt_i) ld_next = prog_s ? LD_COLLECT : LD_WAIT;
         end
         LD_DONE: begin
            pop = avail;
            if (prog_rise) ld_next = LD_COLLECT;
         end
         default: ld_next = LD_WAIT;
      endcase
   end

   // One-deep holding register; a byte arriving while it is full and not
   // being drained is lost and flagged sticky.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         overrun_o <= 1'b0;
      end else if (hold_full) begin
         if (pop) begin
            if (byte_valid) hold_data <= shreg;
            else            hold_full <= 1'b0;
         end else if (byte_valid) begin
            overrun_o <= 1'b1;
         end
      end else if (byte_valid && !pop) begin
         hold_full <= 1'b1;
         hold_data <= shreg;
      end
   end

   // Loader state, word assembly, memory request and boot flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ld_state    <= LD_WAIT;
         lane        <= '0;
         word_q      <= '0;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= BASE_A;
         mem_wdata_o <= '0;
         boot_o      <= 1'b0;
      end else begin
         ld_state <= ld_next;
         case (ld_state)
            LD_WAIT: begin
               lane       <= '0;
               mem_addr_o <= BASE_A;
            end
            LD_COLLECT: begin
               if (!prog_s) begin
                  lane <= '0;
               end else if (take) begin
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0:    word_q[7:0]   <= cur_byte;
                     2'd1:    word_q[15:8]  <= cur_byte;
                     2'd2:    word_q[23:16] <= cur_byte;
                     default: begin
                        if (full_word == END_WORD) begin
                           boot_o <= 1'b1;
                        end else begin
                           mem_req_o   <= 1'b1;
                           mem_wdata_o <= full_word;
                        end
                     end
                  endcase
               end
            end
            LD_WRITE: begin
               if (mem_gnt_i) begin
                  mem_req_o  <= 1'b0;
                  mem_addr_o <= mem_addr_o + WORD_STEP;
               end
            end
            LD_DONE: begin
               if (prog_rise) begin
                  boot_o     <= 1'b0;
                  lane       <= '0;
                  mem_addr_o <= BASE_A;
               end
            end
            default: lane <= '0;
         endcase
      end
   end

endmodule
